// File: rtl/apb_ram_bus_master.sv
// Fabric-side APB3 initiator for the RamBus register map: one command per handshake,
// one SETUP/ACCESS transfer with PREADY timeout, response held until consumed.
module apb_ram_bus_master #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              FAB_RESET_N,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrite,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [DATA_W-1:0] CmdWData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspRData,
  output logic              RspErr,
  output logic              RspTimeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A zero timeout disables the abort; the compare value then never matters.
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t              state_r, next_state_s;
  logic [15:0]         cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0]   paddr_r, paddr_nxt_s;
  logic [DATA_W-1:0]   pwdata_r, pwdata_nxt_s;
  logic                pwrite_r, pwrite_nxt_s;
  logic                psel_r, penable_r;
  logic                cmd_ready_r, rsp_valid_r;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt_s;
  logic                err_r, err_nxt_s;
  logic                to_r, to_nxt_s;
  logic                timeout_s;

  assign timeout_s = TO_EN && (cnt_r == TO_LAST);

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (!FAB_RESET_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      paddr_r     <= {ADDR_W{1'b0}};
      pwdata_r    <= {DATA_W{1'b0}};
      pwrite_r    <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      to_r        <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= cnt_nxt_s;
      paddr_r     <= paddr_nxt_s;
      pwdata_r    <= pwdata_nxt_s;
      pwrite_r    <= pwrite_nxt_s;
      psel_r      <= (next_state_s == ST_SETUP) || (next_state_s == ST_ACCESS);
      penable_r   <= (next_state_s == ST_ACCESS);
      cmd_ready_r <= (next_state_s == ST_IDLE);
      rsp_valid_r <= (next_state_s == ST_RESP);
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
      to_r        <= to_nxt_s;
    end
  end

  // Next-state decode; PREADY takes priority over timeout expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (CmdValid) next_state_s = ST_SETUP;
        else          next_state_s = ST_IDLE;
      end
      ST_SETUP: next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY || timeout_s) next_state_s = ST_RESP;
        else                     next_state_s = ST_ACCESS;
      end
      ST_RESP: begin
        if (RspReady) next_state_s = ST_IDLE;
        else          next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath registers.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    paddr_nxt_s  = paddr_r;
    pwdata_nxt_s = pwdata_r;
    pwrite_nxt_s = pwrite_r;
    rdata_nxt_s  = rdata_r;
    err_nxt_s    = err_r;
    to_nxt_s     = to_r;
    case (state_r)
      ST_IDLE: begin
        if (CmdValid) begin
          paddr_nxt_s  = CmdAddr;
          pwdata_nxt_s = CmdWData;
          pwrite_nxt_s = CmdWrite;
          cnt_nxt_s    = 16'd0;
          rdata_nxt_s  = {DATA_W{1'b0}};
          err_nxt_s    = 1'b0;
          to_nxt_s     = 1'b0;
        end else begin
          cnt_nxt_s    = cnt_r;
        end
      end
      ST_SETUP: cnt_nxt_s = cnt_r;
      ST_ACCESS: begin
        cnt_nxt_s = cnt_r + 16'd1;
        if (PREADY) begin
          rdata_nxt_s = (!pwrite_r && !PSLVERR) ? PRDATA : {DATA_W{1'b0}};
          err_nxt_s   = PSLVERR;
          to_nxt_s    = 1'b0;
        end else if (timeout_s) begin
          rdata_nxt_s = {DATA_W{1'b0}};
          err_nxt_s   = 1'b1;
          to_nxt_s    = 1'b1;
        end else begin
          rdata_nxt_s = rdata_r;
        end
      end
      ST_RESP: cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = 16'd0;
    endcase
  end

  assign CmdReady   = cmd_ready_r;
  assign RspValid   = rsp_valid_r;
  assign RspRData   = rdata_r;
  assign RspErr     = err_r;
  assign RspTimeout = to_r;
  assign PADDR      = paddr_r;
  assign PSEL       = psel_r;
  assign PENABLE    = penable_r;
  assign PWRITE     = pwrite_r;
  assign PWDATA     = pwdata_r;

endmodule
